// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and constants for the arbitrated register bank.
// Imported by the arbiter and the top.
package reg_bank_arbiter_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam state_t STATE_RST  = ARB;
    localparam logic   RVALID_RST = 1'b0;
    localparam int     DATA_RST   = 0;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating priority encoder: first requester at or after ptr wins.
// Purely combinational.
module rr_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int j;

    // scan ptr, ptr+1, ... wrapping, and take the first request
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by NREQ requesters, one access per cycle.
// Round-robin grant with a lock for atomic read-modify-write.
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int AW    = idx_w(DEPTH),
    parameter int IW    = idx_w(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   we,
    input  logic [NREQ-1:0]   lock,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*W-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic              rvalid,
    output logic [IW-1:0]     rid,
    output logic [W-1:0]      rdata
);

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   ptr;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;

    logic            hold;
    logic [NREQ-1:0] gnt_c;
    logic [IW-1:0]   sel;
    logic            fire;
    logic [AW-1:0]   sel_addr;
    logic [W-1:0]    sel_wdata;
    logic [IW-1:0]   ptr_nxt;

    logic [W-1:0]    bank [DEPTH];

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req  (req),
        .ptr  (ptr),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    // the lock owner wins while it keeps requesting, else plain round-robin
    always_comb begin
        hold      = (state == LOCKED) && req[owner];
        gnt_c     = arb_gnt;
        sel       = arb_idx;
        fire      = arb_any;
        if (hold) begin
            gnt_c        = '0;
            gnt_c[owner] = 1'b1;
            sel          = owner;
            fire         = 1'b1;
        end
        gnt       = rst ? gnt_c : '0;
        sel_addr  = addr[int'(sel)*AW +: AW];
        sel_wdata = wdata[int'(sel)*W +: W];
        ptr_nxt   = (sel == IW'(NREQ - 1)) ? '0 : sel + 1'b1;
    end

    // grant FSM: advance pointer past each winner, enter/leave lock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= STATE_RST;
            owner <= '0;
            ptr   <= '0;
        end else if (fire) begin
            ptr <= ptr_nxt;
            if (lock[sel]) begin
                state <= LOCKED;
                owner <= sel;
            end else begin
                state <= ARB;
            end
        end else begin
            state <= ARB;
        end
    end

    // bank storage, written at the granting edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= W'(DATA_RST);
            end
        end else if (fire && we[sel]) begin
            bank[sel_addr] <= sel_wdata;
        end
    end

    // read register: one cycle after a read grant; data and id hold otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid <= RVALID_RST;
            rid    <= '0;
            rdata  <= W'(DATA_RST);
        end else begin
            rvalid <= fire && !we[sel];
            if (fire && !we[sel]) begin
                rid   <= sel;
                rdata <= bank[sel_addr];
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter (NREQ=4, W=8, DEPTH=8).
// Inputs change on the falling edge; outputs are checked there too.
module tb_reg_bank_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [3:0]  lock;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic        rvalid;
    logic [1:0]  rid;
    logic [7:0]  rdata;

    int errors;
    int checks;

    reg_bank_arbiter dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .lock   (lock),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rid    (rid),
        .rdata  (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic put(input int i, input logic w, input logic l,
                       input logic [2:0] a, input logic [7:0] d);
        we[i]          = w;
        lock[i]        = l;
        addr[i*3 +: 3] = a;
        wdata[i*8 +: 8] = d;
    endtask

    task automatic clr();
        req   = '0;
        we    = '0;
        lock  = '0;
        addr  = '0;
        wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        clr();
        req = 4'b1111;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        tick();
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_rid", 32'(rid), 32'h0);
        clr();
        rst = 1'b1;
        tick();

        // round robin over four readers
        req = 4'b1111;
        for (int i = 0; i < 4; i++) put(i, 1'b0, 1'b0, 3'(i), 8'h00);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
            tick();
            chk($sformatf("rr_rvalid%0d", k), 32'(rvalid), 32'h1);
            chk($sformatf("rr_rid%0d", k), 32'(rid), 32'(k % 4));
        end

        // write by 2, then read-after-write by 1
        clr();
        req = 4'b0100;
        put(2, 1'b1, 1'b0, 3'd5, 8'hA5);
        #1;
        chk("wr_gnt", 32'(gnt), 32'h4);
        tick();
        chk("wr_rvalid", 32'(rvalid), 32'h0);
        clr();
        req = 4'b0010;
        put(1, 1'b0, 1'b0, 3'd5, 8'h00);
        #1;
        chk("raw_gnt", 32'(gnt), 32'h2);
        tick();
        chk("raw_rvalid", 32'(rvalid), 32'h1);
        chk("raw_rid", 32'(rid), 32'h1);
        chk("raw_rdata", 32'(rdata), 32'hA5);

        // requester 0 writes addr 3 (later checked cleared by reset)
        clr();
        req = 4'b0001;
        put(0, 1'b1, 1'b0, 3'd3, 8'h3C);
        #1;
        chk("w3_gnt", 32'(gnt), 32'h1);
        tick();
        chk("w3_hold_rdata", 32'(rdata), 32'hA5);

        // lock: requester 1 read then write while everyone requests
        clr();
        req = 4'b1111;
        put(1, 1'b0, 1'b1, 3'd2, 8'h00);
        #1;
        chk("lk_gnt0", 32'(gnt), 32'h2);
        tick();
        chk("lk_rid", 32'(rid), 32'h1);
        put(1, 1'b1, 1'b0, 3'd2, 8'h77);
        #1;
        chk("lk_gnt1", 32'(gnt), 32'h2);
        tick();
        chk("lk_rvalid", 32'(rvalid), 32'h0);
        put(1, 1'b0, 1'b0, 3'd2, 8'h00);
        #1;
        chk("lk_next", 32'(gnt), 32'h4);
        tick();
        chk("lk_next_rid", 32'(rid), 32'h2);
        clr();
        req = 4'b0010;
        put(1, 1'b0, 1'b0, 3'd2, 8'h00);
        #1;
        chk("lk_rd_gnt", 32'(gnt), 32'h2);
        tick();
        chk("lk_rd_data", 32'(rdata), 32'h77);

        // lock abandon by requester 3
        clr();
        req = 4'b1000;
        put(3, 1'b0, 1'b1, 3'd3, 8'h00);
        #1;
        chk("ab_gnt0", 32'(gnt), 32'h8);
        tick();
        clr();
        req = 4'b0001;
        #1;
        chk("ab_gnt1", 32'(gnt), 32'h1);
        tick();
        chk("ab_rid", 32'(rid), 32'h0);
        req = 4'b1100;
        #1;
        chk("ab_arb", 32'(gnt), 32'h4);
        tick();

        // wrap and idle
        req = 4'b1000;
        #1;
        chk("wr3_gnt", 32'(gnt), 32'h8);
        tick();
        req = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("idle_gnt%0d", k), 32'(gnt), 32'h0);
            tick();
        end
        chk("idle_rvalid", 32'(rvalid), 32'h0);
        req = 4'b1001;
        #1;
        chk("wrap_gnt", 32'(gnt), 32'h1);
        tick();

        // mid-run reset with everyone requesting, 2 asking to lock
        req = 4'b1111;
        put(2, 1'b0, 1'b1, 3'd3, 8'h00);
        #1;
        chk("pre_rst_gnt", 32'(gnt), 32'h2);
        tick();
        #1;
        rst = 1'b0;
        #1;
        chk("mrst_gnt", 32'(gnt), 32'h0);
        chk("mrst_rvalid", 32'(rvalid), 32'h0);
        chk("mrst_rdata", 32'(rdata), 32'h0);
        tick();
        chk("mrst_rvalid2", 32'(rvalid), 32'h0);
        clr();
        rst = 1'b1;
        req = 4'b0110;
        #1;
        chk("post_rst_ptr", 32'(gnt), 32'h2);
        tick();
        clr();
        req = 4'b1000;
        put(3, 1'b0, 1'b0, 3'd3, 8'h00);
        #1;
        chk("post_rst_gnt", 32'(gnt), 32'h8);
        tick();
        chk("post_rst_rvalid", 32'(rvalid), 32'h1);
        chk("post_rst_rid", 32'(rid), 32'h3);
        chk("post_rst_rdata", 32'(rdata), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Shares one DFF-based register bank (DEPTH x W, async active-low reset to 0) among NREQ requesters.
- Performs at most one access (read or write) per cycle.
- Grants are round-robin, with an optional lock so one requester can do atomic read-modify-write sequences.
- Sits between requester blocks and the shared configuration/status storage.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 8, data width of each bank entry
- DEPTH, 8, number of bank entries (power of two)
- AW, $clog2(DEPTH), address width (derived, do not override)
- IW, $clog2(NREQ), requester-id width (derived)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester access request
- we  in  NREQ  per-requester write enable (1 = write, 0 = read)
- lock  in  NREQ  per-requester lock: keep grant after this access
- addr  in  NREQ*AW  packed addresses; requester i uses [i*AW +: AW]
- wdata  in  NREQ*W  packed write data; requester i uses [i*W +: W]
- gnt  out  NREQ  one-hot (or zero) combinational grant, current cycle
- rvalid  out  1  registered read-data valid
- rid  out  IW  requester id for the current rdata
- rdata  out  W  registered read data

Behaviour:
- Clock and reset: clk, rising edge. rst is asynchronous and active-low.
- Reset values:
  - all bank entries 0
  - rvalid = 0, rid = 0, rdata = 0
  - round-robin pointer ptr = 0 (requester 0 highest priority)
  - FSM in ARB, owner = 0
  - gnt follows req combinationally, so gnt = 0 while rst is low.
- Handshake:
  - A requester asserts req with we/lock/addr/wdata and holds them stable until it sees gnt[i] = 1.
  - The access commits on the rising edge where gnt[i] = 1.
  - A requester may drop req before grant with no effect.
- Grant rules:
  - gnt is zero or one-hot, never more than one bit.
  - gnt is never asserted for a requester whose req = 0.
- Write: bank[addr_i] <= wdata_i at the granting edge.
- Read:
  - At the granting edge, rdata <= bank[addr_i], rid <= i, rvalid <= 1.
  - Latency is 1 cycle after grant.
  - rvalid is 0 in any cycle after a non-read cycle.
  - rdata and rid hold their last value when rvalid = 0.
- Read-after-write: a write at edge k followed by a read of the same address granted at edge k+1 returns the new data. No bypass is needed because the bank is registered.
- FSM ARB:
  - Grant the first req[j] with j scanning ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1 (mod NREQ).
  - On a grant to j: ptr <= (j+1) mod NREQ.
  - If lock[j] = 1, go to LOCKED with owner <= j.
  - With no req, stay in ARB and leave ptr unchanged.
- FSM LOCKED:
  - Only the owner can be granted: gnt[owner] = req[owner].
  - On an owner grant with lock = 0, return to ARB. ptr stays at owner+1.
  - If req[owner] = 0, release the lock immediately and arbitrate normally in the same cycle as in ARB.
- Wrap-around: with ptr = NREQ-1, priority continues at 0.
- Reset mid-operation: everything returns to its reset value asynchronously. An in-flight lock is dropped. A read granted in the reset cycle produces no rvalid.
- Addresses are always in range because DEPTH = 2^AW. No error path.

Decomposition:
- Package reg_bank_arbiter_pkg:
  - state typedef (ARB, LOCKED)
  - IW/AW helper via $clog2
  - reset constants for the bank and outputs
- Sub-module rr_arbiter (req, ptr -> one-hot gnt, index): purely combinational rotate/priority-encode.
- The FSM, bank storage and read register stay in the top module.

Test Plan:
- Reset: drive rst = 0 mid-run with req = 4'b1111 -> gnt = 0, rvalid = 0, rdata = 0. After release, reading addr 3 returns 8'h00.
- Round-robin: req = 4'b1111, all reads, lock = 0, for 8 cycles -> grants 0,1,2,3,0,1,2,3. rid follows the same sequence one cycle later.
- Write then read: requester 2 writes 8'hA5 to addr 5; the next cycle requester 1 reads addr 5 -> rvalid = 1, rid = 1, rdata = 8'hA5 one cycle after its grant.
- Lock: requester 1 reads addr 2 with lock = 1 while req = 4'b1111. Next cycle it writes with lock = 0 -> gnt = 4'b0010 for both cycles. The next grant goes to requester 2.
- Lock abandon: requester 3 is locked and then drops req while req[0] = 1 -> gnt = 4'b0001 in the same cycle and the FSM is back in ARB.
- Wrap and idle: only req[3] for 1 cycle, then req = 0 for 3 cycles, then req = 4'b1001 -> next grant is requester 0 (ptr wrapped to 0 and held through idle).
